// File: rtl/sort_pkg.sv
// Shared definitions for the bubble-sort control block.
//   state_t          : controller states IDLE, FILL, CMP, SWAP, DONE
//   DEF_N / DEF_W    : default entry count and entry width
// Optional build macro SORT_DESC_EN (see sort_cmp_swap) selects descending order.
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    CMP  = 3'd2,
    SWAP = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int DEF_N = 4;
  localparam int DEF_W = 3;

endpackage

// File: rtl/sort_cmp_swap.sv
// Ordering decision for one adjacent pair of the array.
//   a, b     : entry at index i and entry at index i+1 (unsigned)
//   swap_req : high when the pair is out of order
//   lo, hi   : values to write back to index i and index i+1
// Macro SORT_DESC_EN: when defined the target order is descending,
// otherwise ascending. Equal values never request a swap.
module sort_cmp_swap
  import sort_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         swap_req,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

`ifdef SORT_DESC_EN
  assign swap_req = (a < b);
`else
  assign swap_req = (a > b);
`endif

  // lo/hi are the pair in target order, whichever direction that is.
  assign lo = swap_req ? b : a;
  assign hi = swap_req ? a : b;

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Loads N W-bit values serially, bubble-sorts them in place and then drives
// the sorted-flag register (LD held while sorted, sorted_CLR pulse on restart).
//   CLK, RST_N  : clock, synchronous active-low reset
//   START       : begin a new load+sort (honoured in IDLE/DONE only)
//   DIN/DIN_VLD : serial entry input, one entry per valid cycle in FILL
//   RD_ADDR     : array read index; RD_DATA = mem[RD_ADDR] (combinational)
//   BUSY        : high in FILL, CMP, SWAP
//   LD          : high only in DONE
//   sorted_CLR  : one-cycle pulse after an accepted START
// Macro SORT_DESC_EN selects descending order (handled in sort_cmp_swap).
module bubble_sort_ctrl
  import sort_pkg::*;
#(
  parameter  int N     = DEF_N,
  parameter  int W     = DEF_W,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [W-1:0]     DIN,
  input  logic             DIN_VLD,
  input  logic [IDX_W-1:0] RD_ADDR,
  output logic [W-1:0]     RD_DATA,
  output logic             BUSY,
  output logic             LD,
  output logic             sorted_CLR
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t           state_q, state_d;
  logic [W-1:0]     mem_q [N];
  logic [W-1:0]     mem_d [N];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] pass_end_q, pass_end_d;
  logic             swapped_q, swapped_d;
  logic             ld_q, busy_q, clr_q, clr_d;

  logic [IDX_W-1:0] idx_nxt;
  logic             sw_eff;
  logic             swap_req;
  logic [W-1:0]     lo, hi;

  assign idx_nxt = idx_q + ONE;
  // A SWAP cycle counts as a swap in this pass even before swapped_q updates.
  assign sw_eff  = swapped_q | (state_q == SWAP);

  sort_cmp_swap #(.W(W)) u_cmp (
    .a        (mem_q[idx_q]),
    .b        (mem_q[idx_nxt]),
    .swap_req (swap_req),
    .lo       (lo),
    .hi       (hi)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pass_end_d = pass_end_q;
    swapped_d  = swapped_q;
    mem_d      = mem_q;
    clr_d      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (START) begin
          state_d = FILL;
          idx_d   = '0;
          clr_d   = 1'b1;
        end
      end
      FILL: begin
        if (DIN_VLD) begin
          mem_d[idx_q] = DIN;
          if (idx_q == LAST) begin
            state_d    = CMP;
            idx_d      = '0;
            pass_end_d = LAST;
            swapped_d  = 1'b0;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end
      CMP, SWAP: begin
        if ((state_q == CMP) && swap_req) begin
          state_d = SWAP;
        end else begin
          if (state_q == SWAP) begin
            mem_d[idx_q]   = lo;
            mem_d[idx_nxt] = hi;
          end
          swapped_d = sw_eff;
          // Advance to the next pair, or close the pass.
          if (idx_nxt < pass_end_q) begin
            idx_d   = idx_nxt;
            state_d = CMP;
          end else if (!sw_eff || (pass_end_q == ONE)) begin
            state_d = DONE;
          end else begin
            pass_end_d = pass_end_q - ONE;
            idx_d      = '0;
            swapped_d  = 1'b0;
            state_d    = CMP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pass_end_q <= '0;
      swapped_q  <= 1'b0;
      ld_q       <= 1'b0;
      busy_q     <= 1'b0;
      clr_q      <= 1'b0;
      for (int k = 0; k < N; k++) mem_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pass_end_q <= pass_end_d;
      swapped_q  <= swapped_d;
      mem_q      <= mem_d;
      // Outputs are registered from the next state so they line up with it.
      ld_q       <= (state_d == DONE);
      busy_q     <= (state_d == FILL) || (state_d == CMP) || (state_d == SWAP);
      clr_q      <= clr_d;
    end
  end

  assign RD_DATA    = mem_q[RD_ADDR];
  assign LD         = ld_q;
  assign BUSY       = busy_q;
  assign sorted_CLR = clr_q;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Self-checking bench for bubble_sort_ctrl: directed and random arrays,
// expected results queued at load time and checked by a monitor on LD rise.
// Honours SORT_DESC_EN in its reference model.
module tb_bubble_sort_ctrl;

  localparam int N     = 4;
  localparam int W     = 3;
  localparam int IDX_W = 2;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             START = 1'b0;
  logic [W-1:0]     DIN = '0;
  logic             DIN_VLD = 1'b0;
  logic [IDX_W-1:0] RD_ADDR = '0;
  logic [W-1:0]     RD_DATA;
  logic             BUSY, LD, sorted_CLR;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cyc = 0;
  int zero_req = 0;
  int zero_done = 0;
  logic ld_prev = 1'b0;

  typedef struct packed {
    logic [N-1:0][W-1:0] v;
    int                  lat;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] stim [N];

  bubble_sort_ctrl #(.N(N), .W(W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .DIN        (DIN),
    .DIN_VLD    (DIN_VLD),
    .RD_ADDR    (RD_ADDR),
    .RD_DATA    (RD_DATA),
    .BUSY       (BUSY),
    .LD         (LD),
    .sorted_CLR (sorted_CLR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic bit out_of_order(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SORT_DESC_EN
    return a < b;
`else
    return a > b;
`endif
  endfunction

  // Result from a library sort; cycle count from the plain early-exit bubble sort.
  function automatic exp_t model();
    exp_t         r;
    logic [W-1:0] q[$];
    logic [W-1:0] a [N];
    logic [W-1:0] t;
    int           cmps = 0;
    int           swaps = 0;
    bit           sw;
    for (int i = 0; i < N; i++) begin
      q.push_back(stim[i]);
      a[i] = stim[i];
    end
`ifdef SORT_DESC_EN
    q.rsort();
`else
    q.sort();
`endif
    r.v = '0;
    for (int i = 0; i < N; i++) r.v[i] = q[i];
    for (int pe = N - 1; pe >= 1; pe--) begin
      sw = 1'b0;
      for (int i = 0; i < pe; i++) begin
        cmps++;
        if (out_of_order(a[i], a[i+1])) begin
          t = a[i]; a[i] = a[i+1]; a[i+1] = t;
          swaps++;
          sw = 1'b1;
        end
      end
      if (!sw) break;
    end
    r.lat = cmps + swaps;
    return r;
  endfunction

  // Monitor: owns RD_ADDR; checks each completed sort and zero-array requests.
  always @(negedge CLK) begin
    logic cur_ld;
    exp_t e;
    cur_ld = LD;
    if (zero_req != zero_done) begin
      zero_done = zero_req;
      for (int a = 0; a < N; a++) begin
        RD_ADDR = IDX_W'(a);
        #1;
        chk("rst_rd_data", int'(RD_DATA), 0);
      end
    end
    if (cur_ld && !ld_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ld_unexpected actual=LD_rise required=no_rise");
      end else begin
        e = exp_q.pop_front();
        chk("latency", cyc - wr_cyc, e.lat);
        for (int a = 0; a < N; a++) begin
          RD_ADDR = IDX_W'(a);
          #1;
          chk("rd_data", int'(RD_DATA), int'(e.v[a]));
        end
      end
    end
    ld_prev = cur_ld;
  end

  task automatic run(input int gap, input bit push, input bit poke);
    exp_t e;
    e = model();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("clr_pulse", int'(sorted_CLR), 1);
    chk("ld_low_fill", int'(LD), 0);
    chk("busy_fill", int'(BUSY), 1);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gap; g++) begin
        DIN     = W'($urandom);
        DIN_VLD = 1'b0;
        START   = poke && (g == 0);
        @(posedge CLK); #1;
        START   = 1'b0;
      end
      DIN     = stim[i];
      DIN_VLD = 1'b1;
      @(posedge CLK); #1;
      DIN_VLD = 1'b0;
      DIN     = W'($urandom);
      if (i == 0) chk("clr_one_cycle", int'(sorted_CLR), 0);
    end
    wr_cyc = cyc;
    if (push) exp_q.push_back(e);
    chk("busy_sort", int'(BUSY), 1);
    if (poke) begin
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      chk("busy_start_ignored", int'(BUSY), 1);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (!LD && t < 100) begin
      @(posedge CLK); #1;
      t++;
    end
    chk("ld_done", int'(LD), 1);
    chk("busy_done", int'(BUSY), 0);
    chk("clr_done", int'(sorted_CLR), 0);
  endtask

  task automatic set4(input int a, input int b, input int c, input int d);
    stim[0] = W'(a); stim[1] = W'(b); stim[2] = W'(c); stim[3] = W'(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset.
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ld", int'(LD), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_clr", int'(sorted_CLR), 0);
    RST_N = 1'b1;
    zero_req++;
    @(posedge CLK); #1;

    // Reset while in SWAP: 3,1,2,0 swaps on the very first pair.
    set4(3, 1, 2, 0);
    run(0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    chk("midrst_ld", int'(LD), 0);
    chk("midrst_busy", int'(BUSY), 0);
    chk("midrst_clr", int'(sorted_CLR), 0);
    zero_req++;
    // DIN_VLD in IDLE must not write the array.
    DIN = 3'd7; DIN_VLD = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    DIN_VLD = 1'b0;
    chk("idle_busy", int'(BUSY), 0);
    zero_req++;
    @(posedge CLK); #1;

    set4(3, 1, 2, 0); run(0, 1'b1, 1'b0); wait_done();
    set4(0, 1, 2, 3); run(0, 1'b1, 1'b0); wait_done();
    set4(5, 5, 5, 5); run(2, 1'b1, 1'b0); wait_done();
    set4(7, 6, 5, 4); run(0, 1'b1, 1'b1); wait_done();

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) stim[i] = W'($urandom);
      run(int'($urandom_range(0, 2)), 1'b1, 1'($urandom_range(0, 1)));
      wait_done();
      repeat (int'($urandom_range(0, 2))) @(posedge CLK);
      #1;
    end

    repeat (3) @(posedge CLK);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
